// File: rtl/calendar_gen2.sv
// BCD calendar: day/month/year plus weekday, advanced by day_tick, per-field inc/dec keys and a validated load.
// Supports a 2- or 4-digit year and a /4-only or Gregorian leap rule.
module calendar_gen2 #(
    parameter int unsigned YEAR_DIGITS = 4,
    parameter int unsigned LEAP_MODE   = 1,
    parameter logic [15:0] RST_YEAR    = 16'h2000,
    parameter logic [7:0]  RST_MONTH   = 8'h01,
    parameter logic [7:0]  RST_DAY     = 8'h01,
    parameter logic [2:0]  RST_WDAY    = 3'd6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        day_tick,
    input  logic [2:0]  cnt_inc,
    input  logic [2:0]  cnt_dec,
    input  logic        load,
    input  logic [7:0]  load_day,
    input  logic [7:0]  load_month,
    input  logic [15:0] load_year,
    input  logic [2:0]  load_wday,
    output logic [7:0]  day_bcd,
    output logic [7:0]  month_bcd,
    output logic [15:0] year_bcd,
    output logic [2:0]  weekday,
    output logic        leap,
    output logic        year_wrap,
    output logic        load_err,
    output logic [31:0] Data
);

    localparam logic [15:0] YEAR_MASK = (YEAR_DIGITS == 2) ? 16'h00FF : 16'hFFFF;
    localparam logic [15:0] YEAR_MAX  = (YEAR_DIGITS == 2) ? 16'h0099 : 16'h9999;
    localparam bit          GREG      = (LEAP_MODE == 1) && (YEAR_DIGITS == 4);

    logic [7:0]  day_q,  day_d;
    logic [7:0]  month_q, month_d;
    logic [15:0] year_q, year_d;
    logic [2:0]  wday_q, wday_d;
    logic        wrap_q, wrap_d;
    logic        err_q,  err_d;

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec8(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic [15:0] year_inc(input logic [15:0] y);
        if (y == YEAR_MAX) return '0;
        if (y[7:0] == 8'h99) return {bcd_inc8(y[15:8]), 8'h00};
        return {y[15:8], bcd_inc8(y[7:0])};
    endfunction

    function automatic logic [15:0] year_dec(input logic [15:0] y);
        if (y == '0) return YEAR_MAX;
        if (y[7:0] == 8'h00) return {bcd_dec8(y[15:8]), 8'h99};
        return {y[15:8], bcd_dec8(y[7:0])};
    endfunction

    // 10*t + u is divisible by 4 exactly when 2*t + u is.
    function automatic logic div4(input logic [7:0] v);
        logic [4:0] s;
        s = {v[7:4], 1'b0} + {1'b0, v[3:0]};
        return s[1:0] == 2'd0;
    endfunction

    function automatic logic is_leap(input logic [15:0] y);
        if (!GREG) return div4(y[7:0]);
        return (div4(y[7:0]) && (y[7:0] != 8'h00)) || ((y[7:0] == 8'h00) && div4(y[15:8]));
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] m, input logic [15:0] y);
        case (m)
            8'h02:                      return is_leap(y) ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            default:                    return 8'h31;
        endcase
    endfunction

    function automatic logic nibbles_ok(input logic [31:0] v);
        for (int unsigned i = 0; i < 8; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    logic [15:0] ld_year;
    logic        ld_valid;
    logic [15:0] y_t;
    logic [7:0]  m_t, d_t, len_t;

    assign ld_year = load_year & YEAR_MASK;

    always_comb begin
        ld_valid = nibbles_ok({load_day, load_month, ld_year})
                   && (load_month >= 8'h01) && (load_month <= 8'h12)
                   && (load_day >= 8'h01) && (load_wday <= 3'd6);
        // Only look up the month length once the month itself is known to be sane.
        if (ld_valid)
            ld_valid = load_day <= month_len(load_month, ld_year);
    end

    always_comb begin
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        wday_d  = wday_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        y_t     = year_q;
        m_t     = month_q;
        d_t     = day_q;
        len_t   = month_len(month_q, year_q);
        if (load) begin
            if (ld_valid) begin
                day_d   = load_day;
                month_d = load_month;
                year_d  = ld_year;
                wday_d  = load_wday;
            end else begin
                err_d = 1'b1;
            end
        end else if (day_tick) begin
            wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
            if (day_q < len_t) begin
                day_d = bcd_inc8(day_q);
            end else begin
                day_d = 8'h01;
                if (month_q == 8'h12) begin
                    month_d = 8'h01;
                    year_d  = year_inc(year_q);
                    wrap_d  = 1'b1;
                end else begin
                    month_d = bcd_inc8(month_q);
                end
            end
        end else begin
            // Keys apply year, then month, then clamp/adjust day against the updated month length.
            if (cnt_inc[2])      y_t = year_inc(year_q);
            else if (cnt_dec[2]) y_t = year_dec(year_q);
            if (cnt_inc[1])      m_t = (month_q == 8'h12) ? 8'h01 : bcd_inc8(month_q);
            else if (cnt_dec[1]) m_t = (month_q == 8'h01) ? 8'h12 : bcd_dec8(month_q);
            len_t = month_len(m_t, y_t);
            if (d_t > len_t) d_t = len_t;
            if (cnt_inc[0]) begin
                d_t    = (d_t == len_t) ? 8'h01 : bcd_inc8(d_t);
                wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
            end else if (cnt_dec[0]) begin
                d_t    = (d_t == 8'h01) ? len_t : bcd_dec8(d_t);
                wday_d = (wday_q == 3'd0) ? 3'd6 : wday_q - 3'd1;
            end
            day_d   = d_t;
            month_d = m_t;
            year_d  = y_t;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            day_q   <= RST_DAY;
            month_q <= RST_MONTH;
            year_q  <= RST_YEAR & YEAR_MASK;
            wday_q  <= RST_WDAY;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            wday_q  <= wday_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign day_bcd   = day_q;
    assign month_bcd = month_q;
    assign year_bcd  = year_q;
    assign weekday   = wday_q;
    assign leap      = is_leap(year_q);
    assign year_wrap = wrap_q;
    assign load_err  = err_q;
    assign Data      = {day_q, month_q, year_q};

endmodule

// File: tb/tb_calendar_gen2.sv
// Directed bench for calendar_gen2: expectations queued per step, popped and asserted one cycle later.
module tb_calendar_gen2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        day_tick;
    logic [2:0]  cnt_inc, cnt_dec;
    logic        load;
    logic [7:0]  load_day, load_month;
    logic [15:0] load_year;
    logic [2:0]  load_wday;
    logic [7:0]  day_bcd, month_bcd;
    logic [15:0] year_bcd;
    logic [2:0]  weekday;
    logic        leap, year_wrap, load_err;
    logic [31:0] Data;

    calendar_gen2 #(
        .YEAR_DIGITS(4),
        .LEAP_MODE(1),
        .RST_YEAR(16'h2000),
        .RST_MONTH(8'h01),
        .RST_DAY(8'h01),
        .RST_WDAY(3'd6)
    ) dut (
        .Clk(Clk), .Reset(Reset), .day_tick(day_tick), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec),
        .load(load), .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .load_wday(load_wday), .day_bcd(day_bcd), .month_bcd(month_bcd), .year_bcd(year_bcd),
        .weekday(weekday), .leap(leap), .year_wrap(year_wrap), .load_err(load_err), .Data(Data)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [68:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [68:0] obs;
    assign obs = {Data, day_bcd, month_bcd, year_bcd, weekday, leap, year_wrap, load_err};

    task automatic expect_st(input string tag, input logic [7:0] d, input logic [7:0] m,
                             input logic [15:0] y, input logic [2:0] wd, input logic lp,
                             input logic wr, input logic er);
        exp_t e;
        e.tag = tag;
        e.v   = {d, m, y, d, m, y, wd, lp, wr, er};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty: got %h want <queued entry>", obs);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        assert (obs === e.v)
        else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", e.tag, obs, e.v);
        end
    endtask

    task automatic cycle();
        @(posedge Clk);
        #1;
        day_tick = 1'b0;
        cnt_inc  = '0;
        cnt_dec  = '0;
        load     = 1'b0;
        check_out();
    endtask

    task automatic do_load(input logic [7:0] d, input logic [7:0] m, input logic [15:0] y,
                           input logic [2:0] w);
        load       = 1'b1;
        load_day   = d;
        load_month = m;
        load_year  = y;
        load_wday  = w;
    endtask

    initial begin
        Reset = 1'b1; day_tick = 1'b0; cnt_inc = '0; cnt_dec = '0; load = 1'b0;
        load_day = '0; load_month = '0; load_year = '0; load_wday = '0;
        repeat (2) @(posedge Clk);
        #1;
        expect_st("reset", 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 1'b0, 1'b0);
        check_out();
        Reset = 1'b0;

        day_tick = 1'b1;
        expect_st("tick_after_reset", 8'h02, 8'h01, 16'h2000, 3'd0, 1'b1, 1'b0, 1'b0); cycle();

        do_load(8'h28, 8'h02, 16'h1900, 3'd2);
        expect_st("load_1900", 8'h28, 8'h02, 16'h1900, 3'd2, 1'b0, 1'b0, 1'b0); cycle();
        day_tick = 1'b1;
        expect_st("tick_feb_1900", 8'h01, 8'h03, 16'h1900, 3'd3, 1'b0, 1'b0, 1'b0); cycle();

        do_load(8'h28, 8'h02, 16'h2000, 3'd1);
        expect_st("load_2000", 8'h28, 8'h02, 16'h2000, 3'd1, 1'b1, 1'b0, 1'b0); cycle();
        day_tick = 1'b1;
        expect_st("tick_feb29_2000", 8'h29, 8'h02, 16'h2000, 3'd2, 1'b1, 1'b0, 1'b0); cycle();
        day_tick = 1'b1;
        expect_st("tick_mar1_2000", 8'h01, 8'h03, 16'h2000, 3'd3, 1'b1, 1'b0, 1'b0); cycle();

        do_load(8'h31, 8'h12, 16'h9999, 3'd4);
        expect_st("load_9999", 8'h31, 8'h12, 16'h9999, 3'd4, 1'b0, 1'b0, 1'b0); cycle();
        day_tick = 1'b1;
        expect_st("year_wrap", 8'h01, 8'h01, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0); cycle();
        expect_st("year_wrap_drop", 8'h01, 8'h01, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b0); cycle();

        do_load(8'h31, 8'h03, 16'h2023, 3'd0);
        expect_st("load_mar31", 8'h31, 8'h03, 16'h2023, 3'd0, 1'b0, 1'b0, 1'b0); cycle();
        cnt_inc = 3'b010;
        expect_st("month_inc_clamp", 8'h30, 8'h04, 16'h2023, 3'd0, 1'b0, 1'b0, 1'b0); cycle();

        do_load(8'h29, 8'h02, 16'h2024, 3'd3);
        expect_st("load_feb29", 8'h29, 8'h02, 16'h2024, 3'd3, 1'b1, 1'b0, 1'b0); cycle();
        cnt_inc = 3'b100;
        expect_st("year_inc_clamp", 8'h28, 8'h02, 16'h2025, 3'd3, 1'b0, 1'b0, 1'b0); cycle();

        do_load(8'h31, 8'h04, 16'h2025, 3'd0);
        expect_st("reject_apr31", 8'h28, 8'h02, 16'h2025, 3'd3, 1'b0, 1'b0, 1'b1); cycle();
        expect_st("load_err_drop", 8'h28, 8'h02, 16'h2025, 3'd3, 1'b0, 1'b0, 1'b0); cycle();
        do_load(8'h1A, 8'h05, 16'h2025, 3'd0);
        expect_st("reject_nibble", 8'h28, 8'h02, 16'h2025, 3'd3, 1'b0, 1'b0, 1'b1); cycle();
        do_load(8'h10, 8'h05, 16'h2025, 3'd7);
        expect_st("reject_wday7", 8'h28, 8'h02, 16'h2025, 3'd3, 1'b0, 1'b0, 1'b1); cycle();

        do_load(8'h05, 8'h06, 16'h2024, 3'd2);
        expect_st("load_jun5", 8'h05, 8'h06, 16'h2024, 3'd2, 1'b1, 1'b0, 1'b0); cycle();
        day_tick = 1'b1; cnt_inc = 3'b001;
        expect_st("tick_beats_key", 8'h06, 8'h06, 16'h2024, 3'd3, 1'b1, 1'b0, 1'b0); cycle();
        cnt_inc = 3'b001; cnt_dec = 3'b001;
        expect_st("inc_beats_dec", 8'h07, 8'h06, 16'h2024, 3'd4, 1'b1, 1'b0, 1'b0); cycle();

        do_load(8'h01, 8'h03, 16'h2024, 3'd4);
        expect_st("load_mar1", 8'h01, 8'h03, 16'h2024, 3'd4, 1'b1, 1'b0, 1'b0); cycle();
        cnt_dec = 3'b001;
        expect_st("day_dec_wrap", 8'h31, 8'h03, 16'h2024, 3'd3, 1'b1, 1'b0, 1'b0); cycle();
        cnt_inc = 3'b001;
        expect_st("day_inc_wrap", 8'h01, 8'h03, 16'h2024, 3'd4, 1'b1, 1'b0, 1'b0); cycle();

        do_load(8'h31, 8'h01, 16'h2023, 3'd1);
        expect_st("load_jan31", 8'h31, 8'h01, 16'h2023, 3'd1, 1'b0, 1'b0, 1'b0); cycle();
        cnt_dec = 3'b010;
        expect_st("month_dec_wrap", 8'h31, 8'h12, 16'h2023, 3'd1, 1'b0, 1'b0, 1'b0); cycle();
        cnt_inc = 3'b010;
        expect_st("month_inc_wrap", 8'h31, 8'h01, 16'h2023, 3'd1, 1'b0, 1'b0, 1'b0); cycle();
        cnt_inc = 3'b110;
        expect_st("year_month_inc", 8'h29, 8'h02, 16'h2024, 3'd1, 1'b1, 1'b0, 1'b0); cycle();

        do_load(8'h10, 8'h10, 16'h2010, 3'd6);
        day_tick = 1'b1;
        expect_st("load_beats_tick", 8'h10, 8'h10, 16'h2010, 3'd6, 1'b0, 1'b0, 1'b0); cycle();
        do_load(8'h15, 8'h05, 16'h0000, 3'd0);
        expect_st("load_year0", 8'h15, 8'h05, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0); cycle();
        cnt_dec = 3'b100;
        expect_st("year_dec_wrap", 8'h15, 8'h05, 16'h9999, 3'd0, 1'b0, 1'b0, 1'b0); cycle();

        Reset = 1'b1;
        #2;
        expect_st("async_reset", 8'h01, 8'h01, 16'h2000, 3'd6, 1'b1, 1'b0, 1'b0);
        check_out();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        day_tick = 1'b1;
        expect_st("tick_after_rerelease", 8'h02, 8'h01, 16'h2000, 3'd0, 1'b1, 1'b0, 1'b0); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
